sdram_cmd_mon: RTL and testbench

SDRAM_CMD_MON -- requirements
Module: sdram_cmd_mon

---
 rtl/sdram_cmd_mon.sv | 73 +++++++
 tb/tb_sdram_cmd_mon.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_mon.sv
// sdram_cmd_mon: SDRAM command-bus monitor checking tRP, tRFC, open-bank refresh and refresh interval
module sdram_cmd_mon #(
  parameter int TRP_CYC  = 2,
  parameter int TRFC_CYC = 7,
  parameter int TREF_CYC = 780
) (
  input  logic        mon_clk,
  input  logic        mon_rst,
  input  logic        mon_en,
  input  logic [3:0]  mon_cmd,
  input  logic [1:0]  mon_bank,
  input  logic [12:0] mon_addr,
  output logic [3:0]  bank_open,
  output logic        err_trp,
  output logic        err_trfc,
  output logic        err_open,
  output logic        err_tref,
  output logic        err_any,
  output logic [15:0] ar_cnt
);
  localparam int RW = $clog2(TREF_CYC + 1) < 10 ? 10 : $clog2(TREF_CYC + 1);
  localparam logic [RW-1:0] REF_LIM = RW'(TREF_CYC);
  localparam logic [7:0] TRP_LIM = 8'(TRP_CYC);
  localparam logic [7:0] TRFC_LIM = 8'(TRFC_CYC);
  typedef enum logic [1:0] {ST_IDLE, ST_TRP, ST_TRFC} state_t;
  state_t state;
  logic [7:0] cnt, cnt_inc;
  logic [RW-1:0] ref_cnt, ref_inc;
  logic [3:0] bank_nxt;
  logic is_nop, is_act, is_pre, is_ar, is_mrs, win_done;
  logic trp_e, trfc_e, open_e, tref_e;
  always_comb begin
    is_nop = mon_cmd[3] || mon_cmd[2:0] == 3'b111 || mon_cmd[2:0] == 3'b110;
    is_act = mon_cmd == 4'b0011;
    is_pre = mon_cmd == 4'b0010;
    is_ar = mon_cmd == 4'b0001;
    is_mrs = mon_cmd == 4'b0000;
    cnt_inc = cnt + 8'd1;
    ref_inc = ref_cnt + RW'(1);
    win_done = cnt_inc == (state == ST_TRP ? TRP_LIM : TRFC_LIM);
    bank_nxt = is_act ? bank_open | (4'b0001 << mon_bank) :
               !is_pre ? bank_open :
               mon_addr[10] ? 4'b0000 : bank_open & ~(4'b0001 << mon_bank);
    trp_e = mon_en && state == ST_TRP && (is_act || is_ar || is_mrs);
    trfc_e = mon_en && state == ST_TRFC && !is_nop;
    open_e = mon_en && is_ar && |bank_open;
    tref_e = mon_en && !is_ar && ref_inc == REF_LIM;
  end
  always_ff @(posedge mon_clk or posedge mon_rst)
    if (mon_rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      ref_cnt <= '0;
      bank_open <= '0;
      ar_cnt <= '0;
      err_trp <= 1'b0;
      err_trfc <= 1'b0;
      err_open <= 1'b0;
      err_tref <= 1'b0;
      err_any <= 1'b0;
    end else begin
      state <= is_pre ? ST_TRP : is_ar ? ST_TRFC : (state != ST_IDLE && win_done) ? ST_IDLE : state;
      cnt <= (is_pre || is_ar) ? 8'd1 : (state == ST_IDLE || win_done) ? 8'd0 : cnt_inc;
      bank_open <= bank_nxt;
      ref_cnt <= (is_ar || !mon_en) ? '0 : ref_cnt == REF_LIM ? ref_cnt : ref_inc;
      ar_cnt <= (mon_en && is_ar && ar_cnt != 16'hFFFF) ? ar_cnt + 16'd1 : ar_cnt;
      err_trp <= trp_e;
      err_trfc <= trfc_e;
      err_open <= open_e;
      err_tref <= tref_e;
      err_any <= err_any | trp_e | trfc_e | open_e | tref_e;
    end
endmodule

// File: tb/tb_sdram_cmd_mon.sv
// tb_sdram_cmd_mon: directed self-checking bench for sdram_cmd_mon
module tb_sdram_cmd_mon;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, PRE = 4'b0010;
  localparam logic [3:0] AR = 4'b0001, MRS = 4'b0000, BST = 4'b0110, DES = 4'b1111;
  logic mon_clk = 1'b0, mon_rst = 1'b1, mon_en = 1'b0;
  logic [3:0] mon_cmd = NOP;
  logic [1:0] mon_bank = 2'd0;
  logic [12:0] mon_addr = 13'd0;
  logic [3:0] bank_open;
  logic err_trp, err_trfc, err_open, err_tref, err_any;
  logic [15:0] ar_cnt;
  int total = 0, passed = 0;

  sdram_cmd_mon dut (
    .mon_clk(mon_clk), .mon_rst(mon_rst), .mon_en(mon_en), .mon_cmd(mon_cmd),
    .mon_bank(mon_bank), .mon_addr(mon_addr), .bank_open(bank_open),
    .err_trp(err_trp), .err_trfc(err_trfc), .err_open(err_open),
    .err_tref(err_tref), .err_any(err_any), .ar_cnt(ar_cnt)
  );

  always #5 mon_clk = ~mon_clk;

  task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    mon_cmd = c;
    mon_bank = b;
    mon_addr = a;
    @(posedge mon_clk);
    #1;
    mon_cmd = NOP;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(NOP, 2'd0, 13'd0);
  endtask

  task automatic do_reset(input logic en);
    mon_rst = 1'b1;
    mon_en = en;
    #2;
    mon_rst = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({bank_open, err_trp, err_trfc, err_open, err_tref, err_any, ar_cnt} !== 25'd0)
      $display("FAIL reset_state: bank_open=%b errs=%b%b%b%b%b ar_cnt=%h exp all 0",
               bank_open, err_trp, err_trfc, err_open, err_tref, err_any, ar_cnt);
    else passed++;
    mon_rst = 1'b0;
  endtask

  task automatic test_legal;
    logic seen = 1'b0;
    do_reset(1'b1);
    cyc(PRE, 2'd0, 13'h400);
    seen |= err_trp | err_trfc | err_open | err_tref;
    cyc(NOP, 2'd0, 13'd0);
    seen |= err_trp | err_trfc | err_open | err_tref;
    cyc(AR, 2'd0, 13'd0);
    seen |= err_trp | err_trfc | err_open | err_tref;
    for (int i = 0; i < 6; i++) begin
      cyc(NOP, 2'd0, 13'd0);
      seen |= err_trp | err_trfc | err_open | err_tref;
    end
    cyc(ACT, 2'd2, 13'd0);
    seen |= err_trp | err_trfc | err_open | err_tref;
    total++;
    if (seen !== 1'b0 || err_any !== 1'b0) $display("FAIL legal_noerr: pulse=%b err_any=%b exp 0 0", seen, err_any);
    else passed++;
    total++;
    if (ar_cnt !== 16'd1) $display("FAIL legal_arcnt: ar_cnt=%0d exp 1", ar_cnt);
    else passed++;
    total++;
    if (bank_open !== 4'b0100) $display("FAIL legal_bank: bank_open=%b exp 0100", bank_open);
    else passed++;
  endtask

  task automatic test_trp;
    do_reset(1'b1);
    cyc(PRE, 2'd0, 13'h400);
    total++;
    if (err_trp !== 1'b0) $display("FAIL trp_quiet: err_trp=%b exp 0", err_trp);
    else passed++;
    cyc(AR, 2'd0, 13'd0);
    total++;
    if (err_trp !== 1'b1 || err_any !== 1'b1) $display("FAIL trp_pulse: err_trp=%b err_any=%b exp 1 1", err_trp, err_any);
    else passed++;
    cyc(NOP, 2'd0, 13'd0);
    total++;
    if (err_trp !== 1'b0 || err_any !== 1'b1) $display("FAIL trp_once: err_trp=%b err_any=%b exp 0 1", err_trp, err_any);
    else passed++;
    do_reset(1'b1);
    cyc(PRE, 2'd1, 13'd0);
    cyc(PRE, 2'd2, 13'd0);
    total++;
    if (err_trp !== 1'b0) $display("FAIL trp_prepre: err_trp=%b exp 0", err_trp);
    else passed++;
    cyc(MRS, 2'd0, 13'd0);
    total++;
    if (err_trp !== 1'b1) $display("FAIL trp_restart_mrs: err_trp=%b exp 1", err_trp);
    else passed++;
  endtask

  task automatic test_trfc;
    do_reset(1'b1);
    cyc(AR, 2'd0, 13'd0);
    nops(4);
    cyc(RD, 2'd0, 13'd0);
    total++;
    if (err_trfc !== 1'b1) $display("FAIL trfc_t5: err_trfc=%b exp 1", err_trfc);
    else passed++;
    cyc(NOP, 2'd0, 13'd0);
    total++;
    if (err_trfc !== 1'b0) $display("FAIL trfc_once: err_trfc=%b exp 0", err_trfc);
    else passed++;
    do_reset(1'b1);
    cyc(AR, 2'd0, 13'd0);
    cyc(DES, 2'd0, 13'd0);
    cyc(BST, 2'd0, 13'd0);
    nops(3);
    cyc(RD, 2'd0, 13'd0);
    total++;
    if (err_trfc !== 1'b1) $display("FAIL trfc_t6: err_trfc=%b exp 1", err_trfc);
    else passed++;
    do_reset(1'b1);
    cyc(AR, 2'd0, 13'd0);
    cyc(DES, 2'd0, 13'd0);
    cyc(BST, 2'd0, 13'd0);
    nops(4);
    cyc(RD, 2'd0, 13'd0);
    total++;
    if (err_trfc !== 1'b0 || err_any !== 1'b0) $display("FAIL trfc_t7: err_trfc=%b err_any=%b exp 0 0", err_trfc, err_any);
    else passed++;
  endtask

  task automatic test_open;
    do_reset(1'b1);
    cyc(ACT, 2'd1, 13'd0);
    cyc(ACT, 2'd3, 13'd0);
    total++;
    if (bank_open !== 4'b1010) $display("FAIL open_act: bank_open=%b exp 1010", bank_open);
    else passed++;
    cyc(PRE, 2'd3, 13'd0);
    cyc(PRE, 2'd0, 13'd0);
    nops(3);
    total++;
    if (bank_open !== 4'b0010) $display("FAIL open_pre: bank_open=%b exp 0010", bank_open);
    else passed++;
    cyc(AR, 2'd0, 13'd0);
    total++;
    if (err_open !== 1'b1 || err_trp !== 1'b0) $display("FAIL open_pulse: err_open=%b err_trp=%b exp 1 0", err_open, err_trp);
    else passed++;
    nops(7);
    cyc(PRE, 2'd0, 13'h400);
    total++;
    if (bank_open !== 4'b0000 || err_open !== 1'b0) $display("FAIL open_preall: bank_open=%b err_open=%b exp 0000 0", bank_open, err_open);
    else passed++;
  endtask

  task automatic test_tref;
    logic early = 1'b0, late = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 779; i++) begin
      cyc(NOP, 2'd0, 13'd0);
      early |= err_tref;
    end
    total++;
    if (early !== 1'b0) $display("FAIL tref_early: err_tref seen=%b exp 0", early);
    else passed++;
    cyc(NOP, 2'd0, 13'd0);
    total++;
    if (err_tref !== 1'b1) $display("FAIL tref_pulse: err_tref=%b exp 1", err_tref);
    else passed++;
    for (int i = 0; i < 30; i++) begin
      cyc(NOP, 2'd0, 13'd0);
      late |= err_tref;
    end
    total++;
    if (late !== 1'b0) $display("FAIL tref_repeat: err_tref seen=%b exp 0", late);
    else passed++;
    do_reset(1'b1);
    early = 1'b0;
    nops(779);
    cyc(AR, 2'd0, 13'd0);
    early |= err_tref;
    for (int i = 0; i < 5; i++) begin
      cyc(NOP, 2'd0, 13'd0);
      early |= err_tref;
    end
    total++;
    if (early !== 1'b0 || err_any !== 1'b0) $display("FAIL tref_ar_limit: err_tref seen=%b err_any=%b exp 0 0", early, err_any);
    else passed++;
  endtask

  task automatic test_gating;
    logic seen = 1'b0;
    do_reset(1'b0);
    cyc(ACT, 2'd0, 13'd0);
    cyc(PRE, 2'd1, 13'd0);
    cyc(AR, 2'd0, 13'd0);
    seen |= err_trp | err_open;
    cyc(RD, 2'd0, 13'd0);
    seen |= err_trfc;
    nops(8);
    total++;
    if (seen !== 1'b0 || err_any !== 1'b0) $display("FAIL gate_noerr: pulse=%b err_any=%b exp 0 0", seen, err_any);
    else passed++;
    total++;
    if (bank_open !== 4'b0001 || ar_cnt !== 16'd0) $display("FAIL gate_track: bank_open=%b ar_cnt=%0d exp 0001 0", bank_open, ar_cnt);
    else passed++;
    cyc(PRE, 2'd0, 13'h400);
    mon_en = 1'b1;
    cyc(ACT, 2'd2, 13'd0);
    total++;
    if (err_trp !== 1'b1) $display("FAIL gate_fsm_runs: err_trp=%b exp 1", err_trp);
    else passed++;
    do_reset(1'b0);
    nops(20);
    mon_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 779; i++) begin
      cyc(NOP, 2'd0, 13'd0);
      seen |= err_tref;
    end
    cyc(NOP, 2'd0, 13'd0);
    total++;
    if (seen !== 1'b0 || err_tref !== 1'b1) $display("FAIL gate_refhold: early=%b err_tref=%b exp 0 1", seen, err_tref);
    else passed++;
  endtask

  task automatic test_reset_midwindow;
    do_reset(1'b1);
    cyc(ACT, 2'd2, 13'd0);
    cyc(AR, 2'd0, 13'd0);
    cyc(RD, 2'd0, 13'd0);
    total++;
    if (err_trfc !== 1'b1 || ar_cnt !== 16'd1 || bank_open !== 4'b0100) $display("FAIL mid_pre: err_trfc=%b ar_cnt=%0d bank_open=%b exp 1 1 0100", err_trfc, ar_cnt, bank_open);
    else passed++;
    mon_rst = 1'b1;
    #1;
    total++;
    if ({bank_open, err_trp, err_trfc, err_open, err_tref, err_any, ar_cnt} !== 25'd0)
      $display("FAIL mid_async: bank_open=%b errs=%b%b%b%b%b ar_cnt=%h exp all 0",
               bank_open, err_trp, err_trfc, err_open, err_tref, err_any, ar_cnt);
    else passed++;
    mon_rst = 1'b0;
    cyc(RD, 2'd0, 13'd0);
    total++;
    if (err_trfc !== 1'b0) $display("FAIL mid_fsm_idle: err_trfc=%b exp 0", err_trfc);
    else passed++;
  endtask

  task automatic test_saturate;
    do_reset(1'b1);
    force dut.ar_cnt = 16'hFFFE;
    #1;
    release dut.ar_cnt;
    cyc(AR, 2'd0, 13'd0);
    total++;
    if (ar_cnt !== 16'hFFFF) $display("FAIL sat_inc: ar_cnt=%h exp ffff", ar_cnt);
    else passed++;
    nops(8);
    cyc(AR, 2'd0, 13'd0);
    total++;
    if (ar_cnt !== 16'hFFFF) $display("FAIL sat_hold: ar_cnt=%h exp ffff", ar_cnt);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_legal;
    test_trp;
    test_trfc;
    test_open;
    test_tref;
    test_gating;
    test_reset_midwindow;
    test_saturate;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
